// File: rtl/dungv_pkg.sv
// Shared encodings for the dungv execution core: instruction flags, opcodes,
// memory sub-ops and FSM state values.
package dungv_pkg;

  localparam logic [1:0] FLAG_CTL = 2'd0;
  localparam logic [1:0] FLAG_ALU = 2'd1;
  localparam logic [1:0] FLAG_MOV = 2'd2;
  localparam logic [1:0] FLAG_MEM = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_ROR  = 4'h8;
  localparam logic [3:0] OP_ROL  = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_JEQ  = 4'hC;
  localparam logic [3:0] OP_JNE  = 4'hD;
  localparam logic [3:0] OP_JLTU = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  localparam logic [3:0] MOV_MOV  = 4'h2;
  localparam logic [3:0] MOV_LDI  = 4'h3;
  localparam logic [3:0] CTL_HALT = 4'hF;

  localparam logic [1:0] MEM_LD  = 2'd1;
  localparam logic [1:0] MEM_ST  = 2'd2;
  localparam logic [1:0] MEM_STI = 2'd3;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_LOADWB = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

endpackage

// File: rtl/dungv_alu.sv
// Combinational ALU for opcodes ADD..MUL; results truncated to DATA_W bits.
module dungv_alu
  import dungv_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SH_W-1:0]   amt,
  output logic [DATA_W-1:0] res
);

  logic [SH_W:0] amt_inv;

  always_comb begin
    // amount 0 makes amt_inv == DATA_W, so the wrapped half shifts out to zero
    amt_inv = (SH_W+1)'(DATA_W) - {1'b0, amt};
    res     = a;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHR:  res = a >> amt;
      OP_SHL:  res = a << amt;
      OP_ROR:  res = (a >> amt) | (a << amt_inv);
      OP_ROL:  res = (a << amt) | (a >> amt_inv);
      OP_MUL:  res = a * b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/dungv_core.sv
// Multi-cycle execution core: FETCH/EXEC/LOADWB/HALT FSM, register file, PC,
// data-memory port and a registered result port.
module dungv_core
  import dungv_pkg::*;
#(
  parameter  int                DATA_W   = 16,
  parameter  int                NREGS    = 64,
  parameter  int                PC_W     = 8,
  parameter  int                MEM_AW   = 10,
  parameter  logic [DATA_W-1:0] REG_INIT = '1,
  localparam int                RA_W     = $clog2(NREGS),
  localparam int                SH_W     = $clog2(DATA_W),
  localparam int                IW       = 6 + 2*RA_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [IW-1:0]     instr,
  output logic [MEM_AW-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  // Fetch handshake: instr_req is high only in FETCH; a word is taken on any
  // cycle where instr_req and instr_valid are both high, otherwise FETCH holds.

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [1:0]        flag;
  logic [3:0]        oper;
  logic [RA_W-1:0]   rega, regb;
  logic [DATA_W-1:0] imm, ra_val, rb_val, alu_res;
  logic [PC_W-1:0]   pc_inc, jmp_tgt;
  logic              wb_en, dmem_we_c;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data, dmem_wdata_c;

  assign flag    = instr_q[IW-1 -: 2];
  assign oper    = instr_q[IW-3 -: 4];
  assign rega    = instr_q[IW-7 -: RA_W];
  assign regb    = instr_q[DATA_W +: RA_W];
  assign imm     = instr_q[DATA_W-1:0];
  assign ra_val  = regs_q[rega];
  assign rb_val  = regs_q[regb];
  assign pc_inc  = pc_q + 1'b1;
  assign jmp_tgt = imm[PC_W-1:0];

  dungv_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (oper),
    .a   (ra_val),
    .b   (rb_val),
    .amt (imm[SH_W-1:0]),
    .res (alu_res)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    out_port_d   = out_port_q;
    out_valid_d  = 1'b0;
    wb_en        = 1'b0;
    wb_addr      = rega;
    wb_data      = alu_res;
    dmem_we_c    = 1'b0;
    dmem_wdata_c = ra_val;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (flag)
          FLAG_ALU: begin
            case (oper)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL,
              OP_ROR, OP_ROL, OP_MUL: wb_en = 1'b1;
              OP_NOT: begin
                wb_en   = 1'b1;
                wb_addr = regb;
                wb_data = ~ra_val;
              end
              OP_JEQ:  if (ra_val == rb_val) pc_d = jmp_tgt;
              OP_JNE:  if (ra_val != rb_val) pc_d = jmp_tgt;
              OP_JLTU: if (ra_val < rb_val) pc_d = jmp_tgt;
              OP_JMP:  pc_d = jmp_tgt;
              default: ;
            endcase
          end
          FLAG_MOV: begin
            if (oper == MOV_MOV) begin
              wb_en   = 1'b1;
              wb_data = rb_val;
            end else if (oper == MOV_LDI) begin
              wb_en   = 1'b1;
              wb_data = imm;
            end
          end
          FLAG_MEM: begin
            case (oper[1:0])
              MEM_LD: begin
                state_d = ST_LOADWB;
                pc_d    = pc_q;
              end
              MEM_ST: dmem_we_c = 1'b1;
              MEM_STI: begin
                dmem_we_c    = 1'b1;
                dmem_wdata_c = imm;
              end
              default: ;
            endcase
          end
          default: begin
            if (oper == CTL_HALT) begin
              state_d = ST_HALT;
              pc_d    = pc_q;
            end
          end
        endcase
      end
      ST_LOADWB: begin
        wb_en   = 1'b1;
        wb_data = dmem_rdata;
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase

    // Result port mirrors whatever was written this cycle, register or memory.
    if (wb_en) begin
      out_port_d  = wb_data;
      out_valid_d = 1'b1;
    end else if (dmem_we_c) begin
      out_port_d  = dmem_wdata_c;
      out_valid_d = 1'b1;
    end

    regs_d = regs_q;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= REG_INIT;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      regs_q      <= regs_d;
    end
  end

  assign pc         = pc_q;
  assign instr_req  = (state_q == ST_FETCH);
  assign halted     = (state_q == ST_HALT);
  assign dmem_addr  = imm[MEM_AW-1:0];
  assign dmem_we    = dmem_we_c & ~rst;
  assign dmem_wdata = dmem_wdata_c;
  assign out_port   = out_port_q;
  assign out_valid  = out_valid_q;
  assign dbg_state  = state_q;

endmodule
